// File: rtl/noc_pkg.sv
// Shared NoC definitions for the network-interface controller.
// Holds the default flit geometry, the flit field offsets and the receive
// FSM state type. A flit is laid out as {dest, src, payload}, MSB first.
package noc_pkg;

  localparam int unsigned NOC_DATA_W = 32;
  localparam int unsigned NOC_ADDR_W = 2;

  // Field offsets for the default geometry.
  localparam int unsigned PAYLOAD_LSB = 0;
  localparam int unsigned SRC_LSB     = NOC_DATA_W;
  localparam int unsigned DEST_LSB    = NOC_DATA_W + NOC_ADDR_W;
  localparam int unsigned FLIT_W      = NOC_DATA_W + 2 * NOC_ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DELIVER
  } ni_rx_state_t;

  function automatic int unsigned flit_width(input int unsigned data_w,
                                             input int unsigned addr_w);
    return data_w + 2 * addr_w;
  endfunction

endpackage

// File: rtl/ni_tx_fifo.sv
// Synchronous FIFO used as the NI transmit queue.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   - write request and data; ignored while full
//   pop           - read request; ignored while empty
//   rdata         - head entry (valid while !empty)
//   full, empty   - status derived from the registered occupancy
//   count         - registered occupancy, 0..DEPTH
module ni_tx_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mips_ni_ctrl.sv
// Network-interface controller between the pipelined MIPS core and its local
// NoC router port. Send requests from Execute are queued as flits
// {dest, src, payload} in a TX FIFO; one incoming flit is buffered and handed
// to the register file when a receive instruction executes.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   proc_valid_E, dest_add_E,
//   NI_in                       - send request, destination, payload
//   proc_ready_in_E             - receive request
//   wd_NI, data_valid           - received payload, one-cycle valid pulse
//   stall                       - combinational pipeline freeze
//   net_tx_valid/flit/ready     - flit stream to the router
//   net_rx_valid/flit/ready     - flit stream from the router
//   misroute_cnt                - saturating count of flits for other nodes
module mips_ni_ctrl
  import noc_pkg::*;
#(
  parameter int unsigned DATA_W   = NOC_DATA_W,
  parameter int unsigned ADDR_W   = NOC_ADDR_W,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned NODE_ID  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       proc_valid_E,
  input  logic [ADDR_W-1:0]          dest_add_E,
  input  logic [DATA_W-1:0]          NI_in,
  input  logic                       proc_ready_in_E,
  output logic [DATA_W-1:0]          wd_NI,
  output logic                       data_valid,
  output logic                       stall,
  output logic                       net_tx_valid,
  output logic [DATA_W+2*ADDR_W-1:0] net_tx_flit,
  input  logic                       net_tx_ready,
  input  logic                       net_rx_valid,
  input  logic [DATA_W+2*ADDR_W-1:0] net_rx_flit,
  output logic                       net_rx_ready,
  output logic [7:0]                 misroute_cnt
);

  localparam int unsigned FW = flit_width(DATA_W, ADDR_W);
  localparam logic [ADDR_W-1:0] NODE_ADDR = ADDR_W'(NODE_ID);

  // ---------------- TX path ----------------
  logic                    tx_full, tx_empty, tx_push, tx_pop;
  logic [FW-1:0]           tx_head;
  logic [$clog2(TX_DEPTH):0] tx_count;

  assign tx_push      = proc_valid_E;
  assign net_tx_valid = !tx_empty;
  assign net_tx_flit  = tx_head;
  assign tx_pop       = net_tx_valid && net_tx_ready;

  ni_tx_fifo #(
    .WIDTH (FW),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata ({dest_add_E, NODE_ADDR, NI_in}),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // ---------------- RX path ----------------
  ni_rx_state_t      state_q, state_d;
  logic              rx_full_q, rx_full_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [7:0]        misroute_q, misroute_d;
  logic              rx_stall, rx_take, rx_accept;
  logic [ADDR_W-1:0] rx_dest;

  logic unused_rx_src;
  assign unused_rx_src = ^{net_rx_flit[DATA_W +: ADDR_W], tx_count};

  assign rx_dest      = net_rx_flit[DATA_W + ADDR_W +: ADDR_W];
  assign net_rx_ready = !rx_full_q;
  assign rx_accept    = net_rx_valid && net_rx_ready;

  always_comb begin
    state_d  = state_q;
    rx_stall = 1'b0;
    rx_take  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (proc_ready_in_E) begin
          rx_stall = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        rx_stall = 1'b1;
        if (rx_full_q) begin
          rx_take = 1'b1;
          state_d = DELIVER;
        end
      end
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rx_take only happens with rx_full_q=1, when capture is blocked, so the
  // clear and set of rx_full never compete.
  always_comb begin
    rx_full_d  = rx_full_q;
    rx_data_d  = rx_data_q;
    misroute_d = misroute_q;
    wd_d       = wd_q;
    if (rx_take) begin
      rx_full_d = 1'b0;
      wd_d      = rx_data_q;
    end
    if (rx_accept) begin
      if (rx_dest == NODE_ADDR) begin
        rx_full_d = 1'b1;
        rx_data_d = net_rx_flit[DATA_W-1:0];
      end else if (misroute_q != 8'hFF) begin
        misroute_d = misroute_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_full_q  <= 1'b0;
      rx_data_q  <= '0;
      wd_q       <= '0;
      misroute_q <= '0;
    end else begin
      state_q    <= state_d;
      rx_full_q  <= rx_full_d;
      rx_data_q  <= rx_data_d;
      wd_q       <= wd_d;
      misroute_q <= misroute_d;
    end
  end

  assign wd_NI        = wd_q;
  assign data_valid   = (state_q == DELIVER);
  assign misroute_cnt = misroute_q;
  assign stall        = (proc_valid_E && tx_full) || rx_stall;

endmodule

// File: doc/mips_ni_ctrl.md
Name: mips_ni_ctrl

Overview:
- Network-interface controller between the pipelined MIPS core and its local NoC router port.
- Queues processor send requests from the Execute stage into a TX FIFO and emits them as router flits.
- Buffers one incoming flit and delivers its payload to the register-file write port (wd_NI, data_valid) when a receive instruction executes.
- Drives a pipeline stall while a send cannot be queued or a receive is waiting for data.

Parameters:
- DATA_W, 32, payload width.
- ADDR_W, 2, node address width (4-node mesh).
- TX_DEPTH, 4, TX FIFO entries; power of two, >= 2.
- NODE_ID, 0, this node's address.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- proc_valid_E  in  1  send request from Execute stage.
- dest_add_E  in  ADDR_W  destination node of the send.
- NI_in  in  DATA_W  send payload.
- proc_ready_in_E  in  1  receive request from Execute stage.
- wd_NI  out  DATA_W  received payload to the register file.
- data_valid  out  1  one-cycle pulse: wd_NI is valid.
- stall  out  1  freeze fetch/decode/execute; combinational.
- net_tx_valid  out  1  flit available to router.
- net_tx_flit  out  DATA_W+2*ADDR_W  {dest, src, payload}.
- net_tx_ready  in  1  router accepts flit.
- net_rx_valid  in  1  router presents flit.
- net_rx_flit  in  DATA_W+2*ADDR_W  {dest, src, payload}.
- net_rx_ready  out  1  controller can accept flit.
- misroute_cnt  out  8  saturating count of flits with dest != NODE_ID.

Behaviour:
- Reset (rst=1 at a clock edge) applies regardless of state. It empties the FIFO, clears rx_full, forces the FSM to IDLE and clears misroute_cnt. wd_NI=0 and data_valid=0. In-flight flits are discarded.
- TX push: occurs when proc_valid_E=1 and the registered count < TX_DEPTH. The entry pushed is {dest_add_E, NODE_ID, NI_in}.
- TX full: when proc_valid_E=1 and the FIFO is full, the push is rejected and stall=1 that cycle. This holds even if a pop happens in the same cycle; the push is accepted the next cycle.
- TX pop: net_tx_valid = !empty and net_tx_flit = head entry. Pop when net_tx_valid && net_tx_ready. Flit order is preserved.
- Simultaneous push and pop when not full: the count is unchanged. Pointers wrap modulo TX_DEPTH.
- A push into an empty FIFO becomes visible on net_tx_valid the next cycle (1-cycle latency).
- RX buffer: a one-entry holding register plus rx_full flag; net_rx_ready = !rx_full.
- RX capture: when net_rx_valid && net_rx_ready:
  - dest == NODE_ID: store the payload and set rx_full.
  - otherwise: drop the flit, increment misroute_cnt (saturates at 255), leave rx_full at 0.
- RX FSM states: IDLE, WAIT, DELIVER.
  - IDLE: if proc_ready_in_E=1, then stall=1 and go to WAIT.
  - WAIT: stall=1. If rx_full=1, latch the payload into wd_NI, clear rx_full and go to DELIVER.
  - DELIVER: data_valid=1, stall is not driven by RX, proc_ready_in_E is ignored. Go to IDLE.
- wd_NI holds its value outside DELIVER.
- Minimum receive latency: request seen at cycle t with a flit already buffered gives data_valid at t+2.
- A new flit may be captured during the DELIVER cycle, since rx_full was cleared on entry to DELIVER.
- stall = (proc_valid_E && tx_full) || (state==IDLE && proc_ready_in_E) || (state==WAIT).
- Send and receive requests are independent; both may be asserted in the same cycle.
- Capture and clear of rx_full never coincide, because ready=0 whenever rx_full=1.

Decomposition:
- Shared package (noc_pkg):
  - flit field widths and offsets (PAYLOAD_LSB, SRC_LSB, DEST_LSB);
  - ni_rx_state_t enum {IDLE, WAIT, DELIVER};
  - flit width constant.
- One sub-module, ni_tx_fifo: parameterised synchronous FIFO with push/pop/full/empty/count; the controller instantiates it.

Test Plan:
- Reset, then proc_valid_E=1, dest_add_E=2, NI_in=0xDEADBEEF for 1 cycle with net_tx_ready=1 -> next cycle net_tx_valid=1, net_tx_flit={2,0,0xDEADBEEF}, stall=0 throughout.
- net_tx_ready=0, 5 consecutive sends of 1..5 -> first 4 accepted, stall=1 on the 5th. Raise ready -> flits 1,2,3,4,5 out in order and stall drops the cycle after the first pop.
- Flit {dest=0, src=3, 0x12345678} buffered, then proc_ready_in_E=1 at t -> stall=1 at t and t+1; data_valid=1 and wd_NI=0x12345678 at t+2; net_rx_ready=1 again at t+2.
- proc_ready_in_E=1 with no flit for 10 cycles, then flit arrives -> stall held 1 throughout, data_valid exactly 2 cycles after capture, pulse width 1.
- Flit with dest=1 at NODE_ID=0 -> not delivered, misroute_cnt=1, net_rx_ready stays 1; 300 such flits -> misroute_cnt=255.
- rst=1 while in WAIT with 3 TX entries queued -> next cycle net_tx_valid=0, stall=0, data_valid=0, wd_NI=0, misroute_cnt=0.
